// File: rtl/tpu_pkg.sv
// Shared definitions for the matrix-multiply controller family.
// The state encoding and width helpers are also used by the pin-mapping wrapper.
package tpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    localparam int N_MIN = 2;
    localparam int N_MAX = 8;

    // Flat row-major element index width for an n x n matrix.
    function automatic int idx_w(input int n);
        return $clog2(n * n);
    endfunction

    // Row/column/k counter width; never below one bit.
    function automatic int cnt_w(input int n);
        return (n < N_MIN) ? 1 : $clog2(n);
    endfunction

    // Default accumulator width: full product plus log2(N) growth plus one spare bit.
    function automatic int acc_w_default(input int n, input int dw);
        return 2 * dw + $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/mac_unit.sv
// Single multiply-accumulate step: DW x DW product, signed or unsigned,
// extended to ACC_W and added to either the accumulator or zero.
module mac_unit #(
    parameter int DW    = 8,
    parameter int ACC_W = 18
) (
    input  logic [DW-1:0]    a_i,
    input  logic [DW-1:0]    b_i,
    input  logic             signed_i,
    input  logic             clr_acc_i,
    input  logic [ACC_W-1:0] acc_i,
    output logic [ACC_W-1:0] acc_o
);

    logic signed [2*DW-1:0] prod_s;
    logic        [2*DW-1:0] prod_u;
    logic        [ACC_W-1:0] prod_ext;
    logic        [ACC_W-1:0] base;

    assign prod_s = $signed(a_i) * $signed(b_i);
    assign prod_u = a_i * b_i;

    assign prod_ext = signed_i ? {{(ACC_W-2*DW){prod_s[2*DW-1]}}, prod_s}
                               : {{(ACC_W-2*DW){1'b0}}, prod_u};
    assign base     = clr_acc_i ? '0 : acc_i;
    assign acc_o    = base + prod_ext;

endmodule

// File: rtl/matmul_ctrl_n.sv
// NxN matrix-multiply controller: element-wise operand loading, sequential
// C = AxB or C += AxB with one MAC per cycle, and registered C readback.
module matmul_ctrl_n
    import tpu_pkg::*;
#(
    parameter int N     = 2,
    parameter int DW    = 8,
    parameter int ACC_W = acc_w_default(N, DW),
    parameter int IDX_W = idx_w(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_en,
    input  logic             load_sel_ab,
    input  logic [IDX_W-1:0] load_index,
    input  logic [DW-1:0]    in_data,
    input  logic             start,
    input  logic             acc_mode,
    input  logic             signed_mode,
    input  logic             clear,
    input  logic             output_en,
    input  logic [IDX_W-1:0] output_sel,
    output logic [ACC_W-1:0] out_data,
    output logic             busy,
    output logic             done
);

    localparam int NN = N * N;
    localparam int CW = cnt_w(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_e           state_q;
    logic [DW-1:0]    a_q [NN];
    logic [DW-1:0]    b_q [NN];
    logic [ACC_W-1:0] c_q [NN];
    logic [CW-1:0]    i_q, j_q, k_q;
    logic             acc_q, sgn_q;
    logic [ACC_W-1:0] out_q;
    logic             busy_q, done_q;

    logic [IDX_W-1:0] a_idx, b_idx, c_idx;
    logic             load_ok, read_ok, last_mac, clr_acc;
    logic [ACC_W-1:0] mac_acc;

    assign a_idx    = IDX_W'(i_q) * IDX_W'(N) + IDX_W'(k_q);
    assign b_idx    = IDX_W'(k_q) * IDX_W'(N) + IDX_W'(j_q);
    assign c_idx    = IDX_W'(i_q) * IDX_W'(N) + IDX_W'(j_q);
    assign load_ok  = int'({1'b0, load_index}) < NN;
    assign read_ok  = int'({1'b0, output_sel}) < NN;
    assign last_mac = (i_q == LAST) && (j_q == LAST) && (k_q == LAST);
    assign clr_acc  = (k_q == '0) && !acc_q;

    mac_unit #(
        .DW    (DW),
        .ACC_W (ACC_W)
    ) u_mac (
        .a_i       (a_q[a_idx]),
        .b_i       (b_q[b_idx]),
        .signed_i  (sgn_q),
        .clr_acc_i (clr_acc),
        .acc_i     (c_q[c_idx]),
        .acc_o     (mac_acc)
    );

    // NOTE: the operand and accumulator arrays are reset because a reset must
    // leave A, B and C reading as zero; this keeps them in flops, not RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            for (int e = 0; e < NN; e++) begin
                a_q[e] <= '0;
                b_q[e] <= '0;
                c_q[e] <= '0;
            end
            i_q    <= '0;
            j_q    <= '0;
            k_q    <= '0;
            acc_q  <= 1'b0;
            sgn_q  <= 1'b0;
            out_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            if (output_en) begin
                out_q <= read_ok ? c_q[output_sel] : '0;
            end

            case (state_q)
                ST_COMPUTE: begin
                    c_q[c_idx] <= mac_acc;
                    if (k_q == LAST) begin
                        k_q <= '0;
                        if (j_q == LAST) begin
                            j_q <= '0;
                            i_q <= i_q + CW'(1);
                        end else begin
                            j_q <= j_q + CW'(1);
                        end
                    end else begin
                        k_q <= k_q + CW'(1);
                    end
                    if (last_mac) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end

                default: begin
                    // Loads and clear land on this edge, so a coincident start
                    // computes with the freshly written operands and zeroed C.
                    if (load_en && load_ok) begin
                        if (load_sel_ab) b_q[load_index] <= in_data;
                        else             a_q[load_index] <= in_data;
                    end
                    if (clear) begin
                        for (int e = 0; e < NN; e++) c_q[e] <= '0;
                    end
                    if (start) begin
                        state_q <= ST_COMPUTE;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        acc_q   <= acc_mode;
                        sgn_q   <= signed_mode;
                        i_q     <= '0;
                        j_q     <= '0;
                        k_q     <= '0;
                    end else if (load_en || clear) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign out_data = out_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_matmul_ctrl_n.sv
// Self-checking bench for matmul_ctrl_n (N=2, DW=8): directed scenarios plus
// randomized matrices, checked through a readback scoreboard and a matrix model.
module tb_matmul_ctrl_n;

    localparam int N     = 2;
    localparam int DW    = 8;
    localparam int NN    = N * N;
    localparam int ACC_W = 2 * DW + $clog2(N) + 1;
    localparam int IDX_W = $clog2(NN);
    localparam longint MASK = (longint'(1) << ACC_W) - 1;
    localparam int LAT   = N * N * N;

    logic             clk = 1'b0;
    logic             rst;
    logic             load_en, load_sel_ab, start, acc_mode, signed_mode, clear, output_en;
    logic [IDX_W-1:0] load_index, output_sel;
    logic [DW-1:0]    in_data;
    logic [ACC_W-1:0] out_data;
    logic             busy, done;

    matmul_ctrl_n #(.N(N), .DW(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .load_en     (load_en),
        .load_sel_ab (load_sel_ab),
        .load_index  (load_index),
        .in_data     (in_data),
        .start       (start),
        .acc_mode    (acc_mode),
        .signed_mode (signed_mode),
        .clear       (clear),
        .output_en   (output_en),
        .output_sel  (output_sel),
        .out_data    (out_data),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string  name;
        longint val;
    } exp_t;
    exp_t exp_q[$];

    logic [DW-1:0] ma [NN];
    logic [DW-1:0] mb [NN];
    longint        mc [NN];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Readback monitor: a request sampled on one edge is compared on the next negedge.
    logic rd_v;
    always @(posedge clk or posedge rst) begin
        if (rst) rd_v <= 1'b0;
        else     rd_v <= output_en;
    end

    always @(negedge clk) begin
        if (rd_v) begin
            if (exp_q.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL readback_unexpected: got %0d, expected no readback", out_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check(e.name, longint'(out_data), e.val);
            end
        end
    end

    function automatic longint opv(input logic [DW-1:0] v, input bit sgn);
        return sgn ? longint'($signed(v)) : longint'(v);
    endfunction

    function automatic void model_reset();
        for (int e = 0; e < NN; e++) begin
            ma[e] = '0;
            mb[e] = '0;
            mc[e] = 0;
        end
    endfunction

    function automatic void model_matmul(input bit acc, input bit sgn);
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                longint s;
                s = acc ? mc[i*N+j] : 0;
                for (int k = 0; k < N; k++)
                    s += opv(ma[i*N+k], sgn) * opv(mb[k*N+j], sgn);
                mc[i*N+j] = s & MASK;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input bit sel_b, input int idx, input logic [DW-1:0] val);
        load_en     = 1'b1;
        load_sel_ab = sel_b;
        load_index  = IDX_W'(idx);
        in_data     = val;
        tick();
        load_en = 1'b0;
        if (sel_b) mb[idx] = val;
        else       ma[idx] = val;
    endtask

    task automatic load_mats(input logic [DW-1:0] a [NN], input logic [DW-1:0] b [NN]);
        for (int e = 0; e < NN; e++) load(1'b0, e, a[e]);
        for (int e = 0; e < NN; e++) load(1'b1, e, b[e]);
    endtask

    task automatic read_all(input string tag);
        for (int e = 0; e < NN; e++) begin
            output_en  = 1'b1;
            output_sel = IDX_W'(e);
            exp_q.push_back('{$sformatf("%s_c%0d", tag, e), mc[e]});
            tick();
        end
        output_en = 1'b0;
        tick();
    endtask

    // Starts a computation; optionally with a coincident clear or A load, and
    // optionally with load/start/clear pulses injected mid-COMPUTE.
    task automatic run(input string tag, input bit acc, input bit sgn, input bit with_clear,
                       input bit with_load, input int ld_idx, input logic [DW-1:0] ld_val,
                       input bit disturb);
        int cnt;
        start       = 1'b1;
        acc_mode    = acc;
        signed_mode = sgn;
        clear       = with_clear;
        load_en     = with_load;
        load_sel_ab = 1'b0;
        load_index  = IDX_W'(ld_idx);
        in_data     = ld_val;
        tick();
        start   = 1'b0;
        clear   = 1'b0;
        load_en = 1'b0;
        if (with_load) ma[ld_idx] = ld_val;
        if (with_clear) for (int e = 0; e < NN; e++) mc[e] = 0;
        model_matmul(acc, sgn);
        check({tag, "_busy_at_start"}, busy, 1);
        check({tag, "_done_at_start"}, done, 0);
        cnt = 0;
        while (!done && cnt < 64) begin
            if (disturb && cnt == 2) begin
                load_en     = 1'b1;
                load_sel_ab = 1'b0;
                load_index  = '0;
                in_data     = 8'd9;
                start       = 1'b1;
                clear       = 1'b1;
                acc_mode    = ~acc;
            end
            tick();
            load_en = 1'b0;
            start   = 1'b0;
            clear   = 1'b0;
            cnt++;
        end
        check({tag, "_latency"}, cnt, LAT);
        check({tag, "_busy_at_done"}, busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] a [NN];
        logic [DW-1:0] b [NN];

        rst = 1'b1;
        {load_en, load_sel_ab, start, acc_mode, signed_mode, clear, output_en} = '0;
        load_index = '0;
        output_sel = '0;
        in_data    = '0;
        model_reset();
        tick();
        tick();
        rst = 1'b0;
        tick();

        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_out", out_data, 0);
        read_all("reset");

        // Basic unsigned multiply, then accumulate, then clear.
        a = '{8'd1, 8'd2, 8'd3, 8'd4};
        b = '{8'd5, 8'd6, 8'd7, 8'd8};
        load_mats(a, b);
        run("mul", 1'b0, 1'b0, 1'b0, 1'b0, 0, '0, 1'b0);
        check("mul_done", done, 1);
        read_all("mul");
        check("mul_done_held", done, 1);
        run("acc", 1'b1, 1'b0, 1'b0, 1'b0, 0, '0, 1'b0);
        read_all("acc");
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int e = 0; e < NN; e++) mc[e] = 0;
        check("clear_done_drop", done, 0);
        read_all("clear");

        // Signed operands.
        a = '{8'hFF, 8'h02, 8'h00, 8'h01};
        b = '{8'h03, 8'h00, 8'h01, 8'hFE};
        load_mats(a, b);
        run("sgn", 1'b0, 1'b1, 1'b0, 1'b0, 0, '0, 1'b0);
        read_all("sgn");
        load(1'b0, 3, 8'h01);
        check("load_done_drop", done, 0);

        // Largest unsigned operands, then accumulate until the sum wraps.
        a = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        load_mats(a, a);
        run("max", 1'b0, 1'b0, 1'b0, 1'b0, 0, '0, 1'b0);
        read_all("max");
        run("max_acc1", 1'b1, 1'b0, 1'b0, 1'b0, 0, '0, 1'b0);
        read_all("max_acc1");
        run("max_acc2", 1'b1, 1'b0, 1'b0, 1'b0, 0, '0, 1'b0);
        read_all("max_acc2");

        // Load, start and clear pulsed mid-COMPUTE must be ignored.
        a = '{8'd1, 8'd2, 8'd3, 8'd4};
        b = '{8'd5, 8'd6, 8'd7, 8'd8};
        load_mats(a, b);
        run("dist", 1'b0, 1'b0, 1'b0, 1'b0, 0, '0, 1'b1);
        read_all("dist");
        run("dist_rerun", 1'b0, 1'b0, 1'b0, 1'b0, 0, '0, 1'b0);
        read_all("dist_rerun");

        // Start together with a load and with a clear.
        run("ld_start", 1'b0, 1'b0, 1'b0, 1'b1, 0, 8'd10, 1'b0);
        read_all("ld_start");
        run("clr_start", 1'b1, 1'b0, 1'b1, 1'b0, 0, '0, 1'b0);
        read_all("clr_start");

        // Randomized matrices and modes.
        for (int t = 0; t < 8; t++) begin
            for (int e = 0; e < NN; e++) begin
                a[e] = DW'($urandom);
                b[e] = DW'($urandom);
            end
            load_mats(a, b);
            run($sformatf("rnd%0d", t), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                1'b0, 0, '0, 1'b0);
            read_all($sformatf("rnd%0d", t));
        end

        // Reset during the 4th COMPUTE cycle.
        output_en  = 1'b1;
        output_sel = IDX_W'(3);
        exp_q.push_back('{"pre_rst_c3", mc[3]});
        tick();
        output_en = 1'b0;
        tick();
        start    = 1'b1;
        acc_mode = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_out", out_data, 0);
        model_reset();
        tick();
        rst = 1'b0;
        tick();
        read_all("post_rst");
        run("post_rst_run", 1'b0, 1'b0, 1'b0, 1'b0, 0, '0, 1'b0);
        read_all("post_rst_run");

        tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
